// File: rtl/icache_dm_pkg.sv
// Shared types and address-split helpers for the direct-mapped instruction cache.
package icache_dm_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOOKUP  = 2'd1,
        S_REFILL  = 2'd2,
        S_RESPOND = 2'd3
    } state_t;

    // word-offset bits inside a line
    function automatic int off_w(input int line_words);
        return $clog2(line_words);
    endfunction

    // line-index bits
    function automatic int idx_w(input int num_lines);
        return $clog2(num_lines);
    endfunction

    // tag bits: what remains of the 30-bit word address
    function automatic int tag_w(input int num_lines, input int line_words);
        return 30 - $clog2(num_lines) - $clog2(line_words);
    endfunction

endpackage

// File: rtl/icache_dm_if.sv
// Fetch-side and bus-side handshake bundle of the instruction cache.
// master = fetch unit + bus model side, slave = cache.
interface icache_dm_if;
    logic        fe_req;
    logic [31:0] fe_addr;
    logic        fe_ready;
    logic        fe_kill;
    logic        fe_rvalid;
    logic [31:0] fe_rdata;
    logic        inv;
    logic [31:0] bus_addr;
    logic        bus_ren;
    logic [31:0] bus_rdata;
    logic        bus_done;

    modport master (
        output fe_req, fe_addr, fe_kill, inv, bus_rdata, bus_done,
        input  fe_ready, fe_rvalid, fe_rdata, bus_addr, bus_ren
    );

    modport slave (
        input  fe_req, fe_addr, fe_kill, inv, bus_rdata, bus_done,
        output fe_ready, fe_rvalid, fe_rdata, bus_addr, bus_ren
    );
endinterface

// File: rtl/icache_dm_ram.sv
// Synchronous-read 1R1W RAM used for both the tag and data arrays.
// No reset on contents: validity lives in separate flops in the cache.
module icache_dm_ram #(
    parameter int DW    = 32,
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);
    (* ram_style = "block" *) logic [DW-1:0] mem [DEPTH];

    // write port and registered read port
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/icache_dm.sv
// Direct-mapped L1 instruction cache: 1-cycle hit, blocking in-order line
// refill, flash invalidate, fetch kill and hit/miss counters.
module icache_dm
    import icache_dm_pkg::*;
#(
    parameter int NUM_LINES  = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    icache_dm_if.slave  cif,
    output logic [31:0] perf_hits,
    output logic [31:0] perf_misses
);
    localparam int OFF = off_w(LINE_WORDS);
    localparam int IDX = idx_w(NUM_LINES);
    localparam int TAG = tag_w(NUM_LINES, LINE_WORDS);
    localparam logic [OFF-1:0] LAST_W = OFF'(LINE_WORDS - 1);

    state_t               state, state_nx;
    logic [29:0]          req_addr;      // latched word address of the fetch
    logic [OFF-1:0]       w;             // refill word counter
    logic [31:0]          cap_word;      // requested word captured during refill
    logic [NUM_LINES-1:0] valid;
    logic                 inv_pend;      // invalidate seen during refill
    logic                 kill_pend;     // kill seen during refill
    logic [TAG-1:0]       tag_q;
    logic [31:0]          data_q;

    logic [TAG-1:0] req_tag;
    logic [IDX-1:0] req_idx;
    logic [OFF-1:0] req_word;
    logic           accept, hit, lookup_live, refill_wr, refill_last;
    logic           unused_addr_lsb;

    assign req_tag  = req_addr[29:OFF+IDX];
    assign req_idx  = req_addr[OFF+IDX-1:OFF];
    assign req_word = req_addr[OFF-1:0];
    assign unused_addr_lsb = ^cif.fe_addr[1:0];

    assign accept      = cif.fe_req && cif.fe_ready;
    assign hit         = (state == S_LOOKUP) && valid[req_idx] && (tag_q == req_tag);
    assign lookup_live = (state == S_LOOKUP) && !cif.fe_kill;
    assign refill_wr   = (state == S_REFILL) && cif.bus_done;
    assign refill_last = refill_wr && (w == LAST_W);

    // refill address walks the line in order; stays put until bus_done
    assign cif.bus_addr = {req_addr[29:OFF], w, 2'b00};

    icache_dm_ram #(.DW(32), .DEPTH(NUM_LINES * LINE_WORDS)) u_data (
        .clk   (clk),
        .re    (accept),
        .raddr (cif.fe_addr[OFF+IDX+1:2]),
        .we    (refill_wr),
        .waddr ({req_idx, w}),
        .wdata (cif.bus_rdata),
        .rdata (data_q)
    );

    icache_dm_ram #(.DW(TAG), .DEPTH(NUM_LINES)) u_tag (
        .clk   (clk),
        .re    (accept),
        .raddr (cif.fe_addr[OFF+IDX+1:OFF+2]),
        .we    (refill_last),
        .waddr (req_idx),
        .wdata (req_tag),
        .rdata (tag_q)
    );

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // next-state: a new accept always wins over a kill
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    if (accept) state_nx = S_LOOKUP;
            S_LOOKUP: begin
                if (accept)                    state_nx = S_LOOKUP;
                else if (cif.fe_kill || hit)   state_nx = S_IDLE;
                else                           state_nx = S_REFILL;
            end
            S_REFILL:  if (refill_last)
                           state_nx = (cif.fe_kill || kill_pend) ? S_IDLE : S_RESPOND;
            S_RESPOND: state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    // outputs: ready while idle, or in lookup when the slot frees this cycle
    always_comb begin
        cif.fe_ready  = 1'b0;
        cif.fe_rvalid = 1'b0;
        cif.fe_rdata  = data_q;
        cif.bus_ren   = 1'b0;
        case (state)
            S_IDLE:    cif.fe_ready = 1'b1;
            S_LOOKUP: begin
                cif.fe_ready  = hit || cif.fe_kill;
                cif.fe_rvalid = hit && !cif.fe_kill;
            end
            S_REFILL:  cif.bus_ren = 1'b1;
            S_RESPOND: begin
                cif.fe_rvalid = 1'b1;
                cif.fe_rdata  = cap_word;
            end
            default: ;
        endcase
    end

    // request latch, refill bookkeeping, valid bits and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            req_addr    <= '0;
            w           <= '0;
            cap_word    <= '0;
            valid       <= '0;
            inv_pend    <= 1'b0;
            kill_pend   <= 1'b0;
            perf_hits   <= '0;
            perf_misses <= '0;
        end else begin
            if (accept) req_addr <= cif.fe_addr[31:2];

            if (lookup_live) begin
                if (hit) perf_hits <= perf_hits + 32'd1;
                else begin
                    perf_misses <= perf_misses + 32'd1;
                    w           <= '0;
                    inv_pend    <= 1'b0;
                    kill_pend   <= 1'b0;
                end
            end

            if (state == S_REFILL) begin
                if (cif.inv)     inv_pend  <= 1'b1;
                if (cif.fe_kill) kill_pend <= 1'b1;
            end

            if (refill_wr) begin
                w <= w + OFF'(1);
                if (w == req_word) cap_word <= cif.bus_rdata;
            end

            // a pending invalidate lands after the refilled line is marked valid
            if (refill_last) begin
                if (cif.inv || inv_pend) valid <= '0;
                else                     valid[req_idx] <= 1'b1;
                inv_pend  <= 1'b0;
                kill_pend <= 1'b0;
            end else if (cif.inv && state != S_REFILL) begin
                valid <= '0;
            end
        end
    end
endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm: scoreboard queue of expected fetch words,
// a bus model returning addr ^ 32'hA5A5_0000 with programmable latency.
module tb_icache_dm;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] perf_hits, perf_misses;

    icache_dm_if cif();

    icache_dm #(.NUM_LINES(64), .LINE_WORDS(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .cif         (cif),
        .perf_hits   (perf_hits),
        .perf_misses (perf_misses)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          bus_delay = 0;
    logic [31:0] exp_q [$];
    logic [31:0] bus_log [$];
    int          rv_cyc [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // cycle counter
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // watchdog
    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    // bus model: bus_delay low cycles then bus_done for each word; checks hold
    initial begin : bus_model
        int          bcnt;
        logic        prev_ren, prev_done;
        logic [31:0] prev_addr;
        bcnt = 0; prev_ren = 1'b0; prev_done = 1'b0; prev_addr = '0;
        cif.bus_done  = 1'b0;
        cif.bus_rdata = '0;
        forever begin
            @(negedge clk);
            if (cif.bus_ren && prev_ren && !prev_done)
                chk("bus_addr_hold", cif.bus_addr, prev_addr);
            prev_ren  = cif.bus_ren;
            prev_addr = cif.bus_addr;
            if (cif.bus_ren) begin
                if (bcnt >= bus_delay) begin
                    cif.bus_done  = 1'b1;
                    cif.bus_rdata = mem(cif.bus_addr);
                    bus_log.push_back(cif.bus_addr);
                    bcnt = 0;
                end else begin
                    cif.bus_done = 1'b0;
                    bcnt++;
                end
            end else begin
                cif.bus_done = 1'b0;
                bcnt = 0;
            end
            prev_done = cif.bus_done;
        end
    end

    // monitor: every fe_rvalid consumes one expected word
    initial begin : monitor
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (cif.fe_rvalid) begin
                rv_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_rvalid: got data %h expected no response", cif.fe_rdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("fe_rdata", cif.fe_rdata, e);
                end
            end
        end
    end

    // issue one fetch; returns #1 after the accepting edge
    task automatic fetch(input logic [31:0] a, input bit push);
        int guard;
        cif.fe_req  = 1'b1;
        cif.fe_addr = a;
        if (push) exp_q.push_back(mem(a));
        guard = 0;
        forever begin
            @(negedge clk);
            if (cif.fe_ready) break;
            guard++;
            if (guard > 200) begin
                checks++; failures++;
                $display("FAIL fetch_accept_timeout: addr %h not accepted, expected accept", a);
                break;
            end
        end
        @(posedge clk); #1;
        cif.fe_req = 1'b0;
    endtask

    // wait for all expected responses
    task automatic drain(input string nm);
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() != 0) begin
            checks++; failures++;
            $display("FAIL %s_timeout: %0d responses outstanding, expected 0", nm, exp_q.size());
            exp_q.delete();
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int guard;
        rst = 1'b1;
        cif.fe_req = 1'b0; cif.fe_addr = '0; cif.fe_kill = 1'b0; cif.inv = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // reset state
        @(negedge clk);
        chk("rst_fe_ready",  32'(cif.fe_ready), 32'd1);
        chk("rst_fe_rvalid", 32'(cif.fe_rvalid), 32'd0);
        chk("rst_bus_ren",   32'(cif.bus_ren), 32'd0);
        chk("rst_bus_addr",  cif.bus_addr, 32'd0);
        chk("rst_hits",      perf_hits, 32'd0);
        chk("rst_misses",    perf_misses, 32'd0);
        @(posedge clk); #1;

        // cold miss, single-cycle bus
        bus_delay = 0;
        bus_log.delete();
        fetch(32'h100, 1'b1);
        drain("cold");
        chk("cold_nreads", bus_log.size(), 32'd4);
        for (int i = 0; i < 4 && i < bus_log.size(); i++)
            chk("cold_bus_addr", bus_log[i], 32'h100 + 32'(4 * i));
        chk("cold_misses", perf_misses, 32'd1);
        chk("cold_hits",   perf_hits, 32'd0);

        // back-to-back hits
        bus_log.delete();
        rv_cyc.delete();
        fetch(32'h104, 1'b1);
        fetch(32'h108, 1'b1);
        fetch(32'h10C, 1'b1);
        drain("b2b");
        chk("b2b_nrv", rv_cyc.size(), 32'd3);
        if (rv_cyc.size() == 3) chk("b2b_span", 32'(rv_cyc[2] - rv_cyc[0]), 32'd2);
        chk("b2b_no_bus", bus_log.size(), 32'd0);
        chk("b2b_hits", perf_hits, 32'd3);

        // conflict miss on index 0x10, then original line again
        bus_log.delete();
        fetch(32'h1100, 1'b1);
        drain("conf1");
        if (bus_log.size() > 0) chk("conf_bus_addr0", bus_log[0], 32'h1100);
        fetch(32'h100, 1'b1);
        drain("conf2");
        chk("conf_misses", perf_misses, 32'd3);
        chk("conf_hits",   perf_hits, 32'd3);

        // slow bus with kill mid-refill
        bus_delay = 5;
        bus_log.delete();
        fetch(32'h2000, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("slow_fe_ready", 32'(cif.fe_ready), 32'd0);
        chk("slow_bus_ren",  32'(cif.bus_ren), 32'd1);
        @(posedge clk); #1 cif.fe_kill = 1'b1;
        @(posedge clk); #1 cif.fe_kill = 1'b0;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!(bus_log.size() == 4 && !cif.bus_ren) && guard < 200);
        chk("kill_refill_done", 32'(bus_log.size() == 4 && !cif.bus_ren), 32'd1);
        @(posedge clk); #1;
        bus_delay = 0;
        fetch(32'h100, 1'b1);
        fetch(32'h2004, 1'b1);
        drain("kill_after");
        chk("kill_hits",   perf_hits, 32'd5);
        chk("kill_misses", perf_misses, 32'd4);

        // invalidate during refill of 0x200
        bus_delay = 2;
        fetch(32'h200, 1'b1);
        @(posedge clk); #1 cif.inv = 1'b1;
        @(posedge clk); #1 cif.inv = 1'b0;
        drain("inv1");
        bus_log.delete();
        fetch(32'h200, 1'b1);
        drain("inv2");
        chk("inv_refetch_reads", bus_log.size(), 32'd4);
        chk("inv_misses", perf_misses, 32'd6);

        // reset in the middle of a refill
        bus_delay = 0;
        fetch(32'h100, 1'b1);
        drain("pre_rst");
        chk("pre_rst_misses", perf_misses, 32'd7);
        bus_delay = 3;
        fetch(32'h3000, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_bus_ren", 32'(cif.bus_ren), 32'd1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid_bus_ren", 32'(cif.bus_ren), 32'd0);
        chk("rst_mid_rvalid",  32'(cif.fe_rvalid), 32'd0);
        chk("rst_mid_misses",  perf_misses, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        bus_delay = 0;
        bus_log.delete();
        fetch(32'h100, 1'b1);
        drain("post_rst");
        chk("post_rst_reads",  bus_log.size(), 32'd4);
        chk("post_rst_misses", perf_misses, 32'd1);
        chk("post_rst_hits",   perf_hits, 32'd0);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
